axis_frame_arbiter: RTL and testbench

Round-robin arbiter that shares one `axis_width_conv_narrow_wide` input between K narrow FWFT-style sources. It uses the same `tnext`/`tvalid`/`tfirst` stream convention. Grants change only at frame boundaries (a `tfirst` beat) or after an idle timeout. The first beat of every grant is forced to `tfirst=1`, so the converter flushes any partial word and never mixes sources inside one wide word. It sits between the per-source FIFOs and the converter's `s_axis_*` port.

---
 rtl/axis_frame_arbiter.sv | 173 +++++++++++++++++
 tb/tb_axis_frame_arbiter.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_frame_arbiter.sv
// axis_frame_arbiter
//   Round-robin arbiter that shares one narrow FWFT-style stream (tnext/tvalid/
//   tfirst) between K sources. Grants move only at frame boundaries or after
//   an idle timeout. The first beat of every grant is forced to tfirst=1 so a
//   downstream width converter never packs two sources into one wide word.
//
// Ports
//   clk, rst        : single clock, synchronous active-high reset
//   s_axis_tvalid   : [K]   source k has a head beat
//   s_axis_tdata    : [K*N] source k data at [k*N +: N]
//   s_axis_tfirst   : [K]   source k head beat starts a frame
//   s_axis_tnext    : [K]   pop strobe back to source k (one-hot or zero)
//   m_axis_tvalid   : beat offered to the converter
//   m_axis_tdata    : [N] beat data (0 when not valid)
//   m_axis_tfirst   : frame start / forced first beat of a grant
//   m_axis_tnext    : converter pop strobe
//   grant_idx       : [$clog2(K)] current or last granted source
//   grant_active    : high while a grant is held
//   timeout_count   : [16] saturating count of idle-timeout releases
module axis_frame_arbiter #(
   parameter int K            = 4,
   parameter int N            = 4,
   parameter int IDLE_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [K-1:0]         s_axis_tvalid,
   input  logic [K*N-1:0]       s_axis_tdata,
   input  logic [K-1:0]         s_axis_tfirst,
   output logic [K-1:0]         s_axis_tnext,
   output logic                 m_axis_tvalid,
   output logic [N-1:0]         m_axis_tdata,
   output logic                 m_axis_tfirst,
   input  logic                 m_axis_tnext,
   output logic [$clog2(K)-1:0] grant_idx,
   output logic                 grant_active,
   output logic [15:0]          timeout_count
);

   localparam int              W_K      = $clog2(K);
   localparam int              W_IC     = $clog2(IDLE_TIMEOUT + 1);
   localparam logic [W_IC-1:0] IC_LAST  = W_IC'(IDLE_TIMEOUT - 1);
   localparam logic [W_K-1:0]  IDX_LAST = W_K'(K - 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t          r_state;
   state_t          w_state_nxt;
   logic [W_K-1:0]  r_grant_idx;
   logic [W_K-1:0]  r_last_idx;
   logic            r_beats;
   logic            r_first_pend;
   logic [W_IC-1:0] r_idle_cnt;
   logic [15:0]     r_timeout_count;

   logic            w_g_valid;
   logic            w_g_first;
   logic [N-1:0]    w_g_data;
   logic            w_release_hit;
   logic            w_timeout;
   logic            w_xfer;
   logic            w_hit;
   logic [W_K-1:0]  w_hit_idx;
   logic [W_K:0]    w_sum;

   // Head beat of the granted source.
   always_comb begin
      w_g_valid = 1'b0;
      w_g_first = 1'b0;
      w_g_data  = '0;
      for (int unsigned k = 0; k < K; k++) begin
         if (r_grant_idx == W_K'(k)) begin
            w_g_valid = s_axis_tvalid[k];
            w_g_first = s_axis_tfirst[k];
            w_g_data  = s_axis_tdata[k*N +: N];
         end
      end
   end

   // Round-robin search starting one past the last winner. last_idx < K and
   // the offset is <= K, so one conditional subtraction is a full modulo.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      w_sum     = '0;
      for (int unsigned i = 1; i <= K; i++) begin
         w_sum = {1'b0, r_last_idx} + (W_K+1)'(i);
         if (w_sum >= (W_K+1)'(K))
            w_sum = w_sum - (W_K+1)'(K);
         if (!w_hit && s_axis_tvalid[w_sum[W_K-1:0]]) begin
            w_hit     = 1'b1;
            w_hit_idx = w_sum[W_K-1:0];
         end
      end
   end

   // Next state and the combinational forwarding path.
   always_comb begin
      w_state_nxt   = r_state;
      m_axis_tvalid = 1'b0;
      m_axis_tdata  = '0;
      m_axis_tfirst = 1'b0;
      s_axis_tnext  = '0;
      w_release_hit = 1'b0;
      w_timeout     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_hit)
               w_state_nxt = S_GRANT;
         end
         S_GRANT: begin
            // A new frame after at least one forwarded beat ends the grant;
            // that beat stays in its source to open a later grant.
            w_release_hit = w_g_valid & w_g_first & r_beats;
            w_timeout     = ~w_g_valid & (r_idle_cnt == IC_LAST);
            // Gated by rst so nothing is popped in the reset cycle.
            m_axis_tvalid = w_g_valid & ~w_release_hit & ~rst;
            if (m_axis_tvalid) begin
               m_axis_tdata              = w_g_data;
               m_axis_tfirst             = w_g_first | r_first_pend;
               s_axis_tnext[r_grant_idx] = m_axis_tnext;
            end
            if (w_release_hit || w_timeout)
               w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   assign w_xfer = m_axis_tvalid & m_axis_tnext;

   always_ff @(posedge clk) begin
      if (rst)
         r_state <= S_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_grant_idx     <= '0;
         r_last_idx      <= IDX_LAST;
         r_beats         <= 1'b0;
         r_first_pend    <= 1'b0;
         r_idle_cnt      <= '0;
         r_timeout_count <= '0;
      end else if (r_state == S_IDLE) begin
         if (w_hit) begin
            r_grant_idx  <= w_hit_idx;
            r_last_idx   <= w_hit_idx;
            r_first_pend <= 1'b1;
            r_beats      <= 1'b0;
            r_idle_cnt   <= '0;
         end
      end else begin
         if (w_xfer) begin
            r_beats      <= 1'b1;
            r_first_pend <= 1'b0;
         end
         if (w_g_valid)
            r_idle_cnt <= '0;
         else if (!w_timeout)
            r_idle_cnt <= r_idle_cnt + W_IC'(1);
         if (w_timeout && (r_timeout_count != 16'hFFFF))
            r_timeout_count <= r_timeout_count + 16'd1;
      end
   end

   assign grant_idx     = r_grant_idx;
   assign grant_active  = (r_state == S_GRANT);
   assign timeout_count = r_timeout_count;

endmodule

// File: tb/tb_axis_frame_arbiter.sv
// tb_axis_frame_arbiter
//   Directed bench for axis_frame_arbiter (K=4, N=4, IDLE_TIMEOUT=16).
//   Sources are modelled as FIFOs (arrays with head/tail). A reference model
//   tracks grant ownership from the arbitration rules and is compared against
//   every DUT output each cycle; literal expectations per scenario pin it.
module tb_axis_frame_arbiter;

   localparam int K            = 4;
   localparam int N            = 4;
   localparam int IDLE_TIMEOUT = 16;
   localparam int W_K          = 2;
   localparam int DEPTH        = 64;
   localparam int LOGSZ        = 1024;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [K-1:0]   s_tvalid;
   logic [K*N-1:0] s_tdata;
   logic [K-1:0]   s_tfirst;
   logic [K-1:0]   s_tnext;
   logic           m_tvalid;
   logic [N-1:0]   m_tdata;
   logic           m_tfirst;
   logic           m_tnext;
   logic [W_K-1:0] grant_idx;
   logic           grant_active;
   logic [15:0]    timeout_count;

   axis_frame_arbiter #(.K(K), .N(N), .IDLE_TIMEOUT(IDLE_TIMEOUT)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tdata  (s_tdata),
      .s_axis_tfirst (s_tfirst),
      .s_axis_tnext  (s_tnext),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tdata  (m_tdata),
      .m_axis_tfirst (m_tfirst),
      .m_axis_tnext  (m_tnext),
      .grant_idx     (grant_idx),
      .grant_active  (grant_active),
      .timeout_count (timeout_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   bit chk_en = 1'b0;

   // Source FIFOs: {first, data}
   logic [N:0]   src_mem [K][DEPTH];
   int           head [K];
   int           tail [K];
   logic [K-1:0] en;

   // Forwarded-beat log, taken from the DUT's own pop strobes.
   int   log_n = 0;
   int   log_src   [LOGSZ];
   int   log_data  [LOGSZ];
   int   log_first [LOGSZ];
   int   log_cyc   [LOGSZ];

   // Reference model state
   int md_busy = 0, md_g = 0, md_last = K-1, md_beats = 0, md_fp = 0, md_idle = 0, md_to = 0;
   int exp_pop = -1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   task automatic drive();
      for (int k = 0; k < K; k++) begin
         if (en[k] && head[k] < tail[k]) begin
            s_tvalid[k]       = 1'b1;
            s_tfirst[k]       = src_mem[k][head[k]][N];
            s_tdata[k*N +: N] = src_mem[k][head[k]][N-1:0];
         end else begin
            s_tvalid[k]       = 1'b0;
            s_tfirst[k]       = 1'b0;
            s_tdata[k*N +: N] = '0;
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      if (exp_pop >= 0) head[exp_pop]++;
      drive();
   endtask

   task automatic set_en(input logic [K-1:0] v);
      en = v;
      drive();
   endtask

   task automatic push(input int k, input int d, input bit f);
      src_mem[k][tail[k]] = {f, 4'(d)};
      tail[k]++;
   endtask

   function automatic bit pending();
      bit p = 1'b0;
      for (int k = 0; k < K; k++)
         if (en[k] && head[k] < tail[k]) p = 1'b1;
      return p;
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      for (int k = 0; k < K; k++) begin head[k] = 0; tail[k] = 0; end
      en      = '0;
      m_tnext = 1'b1;
      drive();
      step();
      rst = 1'b0;
      drive();
   endtask

   task automatic run_drain(input int maxc, input bit tog);
      int c = 0;
      while (pending() && c < maxc) begin
         if (tog) m_tnext = ((cyc % 4) != 3);
         step();
         c++;
      end
      chk("drain_bound", 32'(pending()), 32'd0);
      m_tnext = 1'b1;
      repeat (3) step();
   endtask

   // Compare process: expected outputs from the model, then advance the model.
   always @(negedge clk) begin
      int           g;
      bit           gv, rel, ev, ef, hit;
      logic [N-1:0] ed;
      logic [K-1:0] enx;
      int           src;
      g = md_g; gv = 1'b0; rel = 1'b0; ev = 1'b0; ef = 1'b0; ed = '0; enx = '0;
      exp_pop = -1;
      if (md_busy != 0) begin
         gv  = s_tvalid[g];
         rel = gv && s_tfirst[g] && (md_beats > 0);
         ev  = gv && !rel && !rst;
         if (ev) begin
            ed = s_tdata[g*N +: N];
            ef = s_tfirst[g] || (md_fp != 0);
            if (m_tnext) begin
               enx[g]  = 1'b1;
               exp_pop = g;
            end
         end
      end
      if (chk_en) begin
         chk("m_tvalid", 32'(m_tvalid), 32'(ev));
         if (ev) begin
            chk("m_tdata", 32'(m_tdata), 32'(ed));
            chk("m_tfirst", 32'(m_tfirst), 32'(ef));
         end
         chk("s_tnext", 32'(s_tnext), 32'(enx));
         chk("grant_active", 32'(grant_active), 32'(md_busy));
         chk("grant_idx", 32'(grant_idx), 32'(md_g));
         chk("timeout_count", 32'(timeout_count), 32'(md_to));
      end
      if (m_tvalid && m_tnext && (s_tnext != '0) && log_n < LOGSZ) begin
         src = 0;
         for (int k = 0; k < K; k++) if (s_tnext[k]) src = k;
         log_src[log_n]   = src;
         log_data[log_n]  = int'(m_tdata);
         log_first[log_n] = int'(m_tfirst);
         log_cyc[log_n]   = cyc;
         log_n++;
      end
      if (rst) begin
         md_busy = 0; md_g = 0; md_last = K-1; md_beats = 0; md_fp = 0; md_idle = 0; md_to = 0;
      end else if (md_busy == 0) begin
         hit = 1'b0;
         for (int d = 1; d <= K; d++) begin
            if (!hit && s_tvalid[(md_last + d) % K]) begin
               hit     = 1'b1;
               md_g    = (md_last + d) % K;
               md_last = md_g;
            end
         end
         if (hit) begin
            md_busy = 1; md_fp = 1; md_beats = 0; md_idle = 0;
         end
      end else begin
         if (exp_pop >= 0) begin md_beats++; md_fp = 0; end
         if (gv) md_idle = 0;
         else if (md_idle == IDLE_TIMEOUT-1) begin
            md_busy = 0;
            if (md_to < 65535) md_to++;
         end else md_idle++;
         if (rel) md_busy = 0;
      end
      cyc++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int p0, p1, prev, n0;
      int cnt [K];
      en = '0; m_tnext = 1'b1;
      for (int k = 0; k < K; k++) begin head[k] = 0; tail[k] = 0; end
      drive();
      step();
      chk_en = 1'b1;
      do_reset();
      chk("rst_grant_active", 32'(grant_active), 32'd0);
      chk("rst_grant_idx", 32'(grant_idx), 32'd0);
      chk("rst_tvalid", 32'(m_tvalid), 32'd0);

      // Source 1: 8-beat frame then a new frame's first beat.
      for (int i = 0; i < 9; i++) push(1, i + 1, (i == 0 || i == 8));
      p0 = log_n;
      set_en(4'b0010);
      repeat (20) step();
      chk("p1_count", 32'(log_n - p0), 32'd9);
      for (int j = 0; j < 9; j++) begin
         chk("p1_src", 32'(log_src[p0+j]), 32'd1);
         chk("p1_data", 32'(log_data[p0+j]), 32'(j + 1));
         chk("p1_first", 32'(log_first[p0+j]), 32'((j == 0 || j == 8) ? 1 : 0));
      end
      chk("p1_backtoback", 32'(log_cyc[p0+7] - log_cyc[p0]), 32'd7);
      chk("p1_switch_gap", 32'(log_cyc[p0+8] - log_cyc[p0+7]), 32'd3);
      chk("p1_grant_idx", 32'(grant_idx), 32'd1);

      // All four sources, two 3-beat frames each.
      do_reset();
      for (int k = 0; k < K; k++)
         for (int i = 0; i < 6; i++) push(k, k*4 + i, (i % 3) == 0);
      p0 = log_n;
      set_en(4'b1111);
      run_drain(200, 1'b0);
      chk("p2_count", 32'(log_n - p0), 32'd24);
      n0 = 0;
      for (int j = p0; j < log_n; j++) begin
         if (log_first[j] != 0) begin
            chk("p2_order", 32'(log_src[j]), 32'(n0 % 4));
            n0++;
         end else if (j > p0) begin
            chk("p2_no_mix", 32'(log_src[j]), 32'(log_src[j-1]));
         end
      end
      chk("p2_grants", 32'(n0), 32'd8);

      // Idle timeout: source 2 stalls mid-frame while source 0 waits.
      do_reset();
      push(2, 5, 1'b0); push(2, 6, 1'b0); push(2, 7, 1'b0);
      push(0, 8, 1'b0); push(0, 9, 1'b0);
      p0 = log_n;
      set_en(4'b0100);
      step();
      set_en(4'b0101);
      repeat (26) step();
      chk("p3_count", 32'(log_n - p0), 32'd5);
      chk("p3_src2_first", 32'(log_first[p0]), 32'd1);
      chk("p3_src0", 32'(log_src[p0+3]), 32'd0);
      chk("p3_src0_forced_first", 32'(log_first[p0+3]), 32'd1);
      chk("p3_timeout_gap", 32'(log_cyc[p0+3] - log_cyc[p0+2]), 32'd18);
      chk("p3_timeout_count", 32'(timeout_count), 32'd1);

      // Reset mid-frame of source 3.
      do_reset();
      for (int i = 0; i < 6; i++) push(3, 10 + i, i == 0);
      push(1, 1, 1'b1); push(1, 2, 1'b0);
      p0 = log_n;
      set_en(4'b1000);
      step();
      step();
      rst = 1'b1;
      set_en(4'b1010);
      step();
      rst = 1'b0;
      drive();
      chk("p4_no_pop_in_reset", 32'(log_n - p0), 32'd1);
      chk("p4_idle_after_reset", 32'(grant_active), 32'd0);
      chk("p4_timeout_count", 32'(timeout_count), 32'd0);
      repeat (3) step();
      chk("p4_regrant_src", 32'(log_src[p0+1]), 32'd1);
      chk("p4_regrant_data", 32'(log_data[p0+1]), 32'd1);
      chk("p4_regrant_first", 32'(log_first[p0+1]), 32'd1);
      run_drain(200, 1'b0);

      // Converter stalls for 20 cycles with source 1 valid.
      do_reset();
      for (int i = 0; i < 4; i++) push(1, 3 + i, i == 0);
      m_tnext = 1'b0;
      p0 = log_n;
      set_en(4'b0010);
      repeat (20) step();
      chk("p5_no_pops", 32'(log_n - p0), 32'd0);
      chk("p5_grant_idx", 32'(grant_idx), 32'd1);
      chk("p5_grant_active", 32'(grant_active), 32'd1);
      chk("p5_no_timeout", 32'(timeout_count), 32'd0);
      m_tnext = 1'b1;
      run_drain(100, 1'b0);
      chk("p5_drained", 32'(log_n - p0), 32'd4);

      // Four interleaved streams with a stalling consumer.
      do_reset();
      for (int k = 0; k < K; k++) begin
         cnt[k] = 0;
         for (int i = 0; i < 24; i++) push(k, (k*5 + i*3) % 16, (i % 5) == 0);
      end
      p0 = log_n;
      set_en(4'b1111);
      run_drain(1500, 1'b1);
      p1 = log_n;
      chk("p6_total", 32'(p1 - p0), 32'd96);
      prev = -1;
      for (int j = p0; j < p1; j++) begin
         chk("p6_order", 32'(log_data[j]), 32'((log_src[j]*5 + cnt[log_src[j]]*3) % 16));
         cnt[log_src[j]]++;
         if (prev >= 0 && log_src[j] != prev)
            chk("p6_switch_first", 32'(log_first[j]), 32'd1);
         prev = log_src[j];
      end
      for (int k = 0; k < K; k++) chk("p6_per_src", 32'(cnt[k]), 32'd24);

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
